// File: rtl/inst_fetch.sv
// Instruction fetch stage: drives the instruction memory from a local pc and
// buffers returned {pc, inst} pairs in a small FIFO for the decode stage.
// Redirects (flush has priority over branch) empty the FIFO and reload pc.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ce,
    output logic [31:0] addr,
    input  logic [31:0] inst_i,
    input  logic        stall_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    input  logic        flush_i,
    input  logic [31:0] new_pc_i,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = $clog2(QDEPTH + 1);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(QDEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(QDEPTH - 1);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_RUN,
        ST_HOLD
    } state_t;

    state_t             r_state;
    logic [31:0]        r_pc;
    logic [CNT_W-1:0]   r_count;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [31:0]        r_q_inst [QDEPTH];
    logic [31:0]        r_q_pc   [QDEPTH];

    logic               w_redirect;
    logic [31:0]        w_redirect_pc;
    logic               w_not_empty;
    logic               w_pop;
    logic               w_has_room;
    logic               w_push;
    logic [PTR_W-1:0]   w_rd_ptr_nxt;
    logic [PTR_W-1:0]   w_wr_ptr_nxt;

    // Redirect selection and the push/pop handshake for this cycle
    always_comb begin
        w_redirect    = flush_i | branch_flag_i;
        w_redirect_pc = flush_i ? new_pc_i : branch_target_i;
        w_redirect_pc = {w_redirect_pc[31:2], 2'b00};
        w_not_empty   = (r_count != '0);
        // A redirect discards any pop requested in the same cycle
        w_pop         = w_not_empty && out_ready && !w_redirect;
        // A full queue may still accept an entry when the head leaves this cycle
        w_has_room    = (r_count < CNT_FULL) || w_pop;
        // Stall pauses fetch immediately, before the state reaches HOLD
        w_push        = (r_state == ST_RUN) && !stall_i && !w_redirect && w_has_room;
    end

    // Pointer increment with wrap at the configured depth (depth need not be a power of two)
    always_comb begin
        w_rd_ptr_nxt = (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
        w_wr_ptr_nxt = (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
    end

    // Memory interface and head-of-queue outputs
    always_comb begin
        ce        = w_push;
        addr      = r_pc;
        out_valid = w_not_empty;
        out_inst  = '0;
        out_pc    = '0;
        if (w_not_empty) begin
            out_inst = r_q_inst[r_rd_ptr];
            out_pc   = r_q_pc[r_rd_ptr];
        end
    end

    // Control FSM: INIT for one cycle after reset, then RUN/HOLD following stall_i
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_INIT;
        end else begin
            case (r_state)
                ST_INIT: r_state <= ST_RUN;
                ST_RUN:  if (stall_i)  r_state <= ST_HOLD;
                ST_HOLD: if (!stall_i) r_state <= ST_RUN;
                default: r_state <= ST_INIT;
            endcase
        end
    end

    // Program counter: redirect reload in any state, otherwise advance on each fetch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (w_redirect) begin
            r_pc <= w_redirect_pc;
        end else if (w_push) begin
            r_pc <= r_pc + 32'd4;
        end
    end

    // Queue bookkeeping: redirect empties the queue, otherwise track push/pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else if (w_redirect) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            if (w_pop) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            if (w_push) begin
                r_wr_ptr <= w_wr_ptr_nxt;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Queue storage; contents are don't-care while the entry is not counted
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_inst[r_wr_ptr] <= inst_i;
            r_q_pc[r_wr_ptr]   <= r_pc;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: a cycle model tracks pc and state, and a
// scoreboard queue holds the {pc, inst} pairs expected at the decode side.
module tb_inst_fetch;

    localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
    localparam int          QD     = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ce;
    logic [31:0] addr;
    logic [31:0] inst_i;
    logic        stall_i = 1'b0;
    logic        branch_flag_i = 1'b0;
    logic [31:0] branch_target_i = '0;
    logic        flush_i = 1'b0;
    logic [31:0] new_pc_i = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_inst;
    logic [31:0] out_pc;

    logic [31:0] mem_xor = '0;

    int n_checks = 0;
    int n_errors = 0;

    // Bench model state
    logic [63:0] sb[$];
    logic [31:0] m_pc;
    int          m_state;   // 0 INIT, 1 RUN, 2 HOLD

    inst_fetch #(.RESET_PC(RST_PC), .QDEPTH(QD)) dut (
        .clk(clk), .rst(rst), .ce(ce), .addr(addr), .inst_i(inst_i),
        .stall_i(stall_i), .branch_flag_i(branch_flag_i),
        .branch_target_i(branch_target_i), .flush_i(flush_i),
        .new_pc_i(new_pc_i), .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_pc(out_pc)
    );

    // Combinational instruction memory: word is a fixed function of address
    assign inst_i = addr ^ mem_xor;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_pc    = RST_PC;
        m_state = 0;
    endtask

    // One clock: compare outputs against the model, then advance the model at the edge
    task automatic step();
        logic        redir;
        logic        pop;
        logic        mce;
        logic [31:0] hpc;
        logic [31:0] hinst;
        logic [31:0] tgt;
        #1;
        redir = flush_i | branch_flag_i;
        tgt   = flush_i ? new_pc_i : branch_target_i;
        pop   = (sb.size() != 0) && out_ready && !redir;
        mce   = (m_state == 1) && !stall_i && !redir && ((sb.size() < QD) || pop);
        hpc   = '0;
        hinst = '0;
        if (sb.size() != 0) begin
            hpc   = sb[0][63:32];
            hinst = sb[0][31:0];
        end
        check("ce", {31'b0, ce}, {31'b0, mce});
        check("addr", addr, m_pc);
        check("out_valid", {31'b0, out_valid}, {31'b0, sb.size() != 0});
        check("out_pc", out_pc, hpc);
        check("out_inst", out_inst, hinst);
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (redir) begin
                sb.delete();
                m_pc = {tgt[31:2], 2'b00};
            end else begin
                if (pop) void'(sb.pop_front());
                if (mce) begin
                    sb.push_back({m_pc, m_pc ^ mem_xor});
                    m_pc = m_pc + 32'd4;
                end
            end
            case (m_state)
                0: m_state = 1;
                1: if (stall_i) m_state = 2;
                default: if (!stall_i) m_state = 1;
            endcase
        end
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Asynchronous reset assertion: outputs must clear without a clock edge
    task automatic async_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_addr", addr, RST_PC);
        check("rst_ce", {31'b0, ce}, 32'd0);
        check("rst_pc", out_pc, 32'd0);
        @(negedge clk);
        run(2);
        rst = 1'b0;
    endtask

    initial begin
        #2 rst = 1'b1;
        @(negedge clk);
        model_reset();
        run(3);

        // Reset release, decode always ready, inst == addr; pc wraps past FFFF_FFFC
        rst = 1'b0;
        run(8);

        // Decode stalls: queue fills to QD entries then ce drops; then drain
        out_ready = 1'b0;
        run(6);
        out_ready = 1'b1;
        run(4);

        // Branch to unaligned target while queue is full
        out_ready = 1'b0;
        run(5);
        branch_flag_i = 1'b1;
        branch_target_i = 32'h0000_1003;
        step();
        branch_flag_i = 1'b0;
        check("br_valid", {31'b0, out_valid}, 32'd0);
        check("br_addr", addr, 32'h0000_1000);
        out_ready = 1'b1;
        run(3);

        // Flush wins over a simultaneous branch
        flush_i = 1'b1;
        new_pc_i = 32'h0000_0180;
        branch_flag_i = 1'b1;
        branch_target_i = 32'h0000_0400;
        step();
        flush_i = 1'b0;
        branch_flag_i = 1'b0;
        check("flush_addr", addr, 32'h0000_0180);
        run(4);

        // Stall pulse across a pc wrap
        flush_i = 1'b1;
        new_pc_i = 32'hFFFF_FFF8;
        step();
        flush_i = 1'b0;
        run(2);
        stall_i = 1'b1;
        run(2);
        stall_i = 1'b0;
        run(5);

        // Redirect while in HOLD, with decode not ready so the queue is non-empty
        out_ready = 1'b0;
        run(3);
        stall_i = 1'b1;
        run(2);
        branch_flag_i = 1'b1;
        branch_target_i = 32'h0000_3006;
        step();
        branch_flag_i = 1'b0;
        run(2);
        stall_i = 1'b0;
        out_ready = 1'b1;
        run(4);

        // Mid-operation reset, then a branch in the INIT cycle
        out_ready = 1'b0;
        run(3);
        async_reset();
        branch_flag_i = 1'b1;
        branch_target_i = 32'h0000_2002;
        step();
        branch_flag_i = 1'b0;
        check("init_br_addr", addr, 32'h0000_2000);
        out_ready = 1'b1;
        run(4);

        // Randomised traffic with a non-trivial memory pattern
        mem_xor = 32'h1357_9BDF;
        for (int i = 0; i < 400; i++) begin
            stall_i         = ($urandom_range(7) == 0);
            branch_flag_i   = ($urandom_range(15) == 0);
            flush_i         = ($urandom_range(31) == 0);
            branch_target_i = $urandom;
            new_pc_i        = $urandom;
            out_ready       = ($urandom_range(3) != 0);
            step();
        end
        stall_i = 1'b0;
        branch_flag_i = 1'b0;
        flush_i = 1'b0;
        out_ready = 1'b1;
        run(6);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1);
    end

endmodule
